// File: rtl/axi4_slave_write_resp_tracker.sv
// AXI4 slave write-path tracker: in-order B responses, outstanding limit, burst-length vs WLAST check.
// Optional macro AXI4_WLAST_CHECK_EN enables WLAST violation reporting (wlast_err, SLVERR).
module axi4_slave_write_resp_tracker #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [7:0]          awlen,
  input  logic                awvalid,
  output logic                awready,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic [CNT_W-1:0]    outstanding_count,
  output logic                wlast_err
);

  localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } bresp_e;

  logic [ID_WIDTH-1:0] aw_id_mem  [FIFO_DEPTH];
  logic [7:0]          aw_len_mem [FIFO_DEPTH];
  logic [ID_WIDTH-1:0] b_id_mem   [FIFO_DEPTH];
  logic [1:0]          b_resp_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]    aw_wr_q, aw_rd_q, b_wr_q, b_rd_q;
  logic [PTR_W-1:0]    aw_wr_n, aw_rd_n, b_wr_n, b_rd_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [7:0]          beat_q, beat_n;
  logic                burst_err_q, burst_err_n;
  logic                awready_q, wready_q, bvalid_q, wlast_err_q;
  logic [ID_WIDTH-1:0] bid_q, bid_n;
  logic [1:0]          bresp_q, bresp_n;

  logic                aw_hs, w_hs, b_hs;
  logic                last_idx, final_beat, violation;
  logic [ID_WIDTH-1:0] head_id;
  logic [7:0]          head_len;
  bresp_e              resp_push;

`ifndef AXI4_WLAST_CHECK_EN
  logic unused_wlast;
  assign unused_wlast = wlast;
`endif

  // Next-state for pointers, counters and the registered B-channel head.
  always_comb begin
    aw_hs      = awvalid && awready_q;
    w_hs       = wvalid && wready_q;
    b_hs       = bvalid_q && bready;
    head_id    = aw_id_mem[aw_rd_q[IDX_W-1:0]];
    head_len   = aw_len_mem[aw_rd_q[IDX_W-1:0]];
    last_idx   = (beat_q == head_len);
    final_beat = w_hs && last_idx;
`ifdef AXI4_WLAST_CHECK_EN
    violation  = w_hs && (wlast != last_idx);
`else
    violation  = 1'b0;
`endif
    resp_push  = (burst_err_q || violation) ? RESP_SLVERR : RESP_OKAY;

    aw_wr_n = aw_wr_q + PTR_W'(aw_hs);
    aw_rd_n = aw_rd_q + PTR_W'(final_beat);
    b_wr_n  = b_wr_q + PTR_W'(final_beat);
    b_rd_n  = b_rd_q + PTR_W'(b_hs);
    cnt_n   = cnt_q + CNT_W'(aw_hs) - CNT_W'(b_hs);

    beat_n      = beat_q;
    burst_err_n = burst_err_q;
    if (final_beat) begin
      beat_n      = 8'd0;
      burst_err_n = 1'b0;
    end else if (w_hs) begin
      beat_n      = beat_q + 8'd1;
      burst_err_n = burst_err_q || violation;
    end

    // The next head is either already stored or is the entry being pushed now.
    bid_n   = bid_q;
    bresp_n = bresp_q;
    if (b_rd_n != b_wr_q) begin
      bid_n   = b_id_mem[b_rd_n[IDX_W-1:0]];
      bresp_n = b_resp_mem[b_rd_n[IDX_W-1:0]];
    end else if (final_beat) begin
      bid_n   = head_id;
      bresp_n = resp_push;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wr_q     <= '0;
      aw_rd_q     <= '0;
      b_wr_q      <= '0;
      b_rd_q      <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      burst_err_q <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      wlast_err_q <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
    end else begin
      aw_wr_q     <= aw_wr_n;
      aw_rd_q     <= aw_rd_n;
      b_wr_q      <= b_wr_n;
      b_rd_q      <= b_rd_n;
      cnt_q       <= cnt_n;
      beat_q      <= beat_n;
      burst_err_q <= burst_err_n;
      awready_q   <= (cnt_n < CNT_W'(FIFO_DEPTH));
      wready_q    <= (aw_wr_n != aw_rd_n);
      bvalid_q    <= (b_wr_n != b_rd_n);
      wlast_err_q <= violation;
      bid_q       <= bid_n;
      bresp_q     <= bresp_n;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      aw_id_mem[aw_wr_q[IDX_W-1:0]]  <= awid;
      aw_len_mem[aw_wr_q[IDX_W-1:0]] <= awlen;
    end
    if (final_beat) begin
      b_id_mem[b_wr_q[IDX_W-1:0]]   <= head_id;
      b_resp_mem[b_wr_q[IDX_W-1:0]] <= resp_push;
    end
  end

  assign awready           = awready_q;
  assign wready            = wready_q;
  assign bvalid            = bvalid_q;
  assign bid               = bid_q;
  assign bresp             = bresp_q;
  assign outstanding_count = cnt_q;
  assign wlast_err         = wlast_err_q;

endmodule

// File: tb/tb_axi4_slave_write_resp_tracker.sv
// Bench for axi4_slave_write_resp_tracker: queue-based reference model, directed scenarios, random traffic.
module tb_axi4_slave_write_resp_tracker;

  localparam int unsigned IDW   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;
`ifdef AXI4_WLAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [IDW-1:0] awid = '0;
  logic [7:0]     awlen = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic           wlast = 1'b0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [IDW-1:0] bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [CW-1:0]  outstanding_count;
  logic           wlast_err;

  axi4_slave_write_resp_tracker #(
    .ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .outstanding_count(outstanding_count), .wlast_err(wlast_err)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [IDW-1:0] id; int len; } aw_t;
  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_t;

  aw_t m_awq[$];
  b_t  m_bq[$];
  int  m_beats = 0;
  int  m_cnt = 0;
  bit  m_err = 1'b0;
  bit  m_started = 1'b0;
  bit  m_wlast_err = 1'b0;

  int  n_checks = 0;
  int  n_fail = 0;

  function automatic bit e_awready();
    return m_started && (m_cnt < int'(DEPTH));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: writes wait in an address queue, completed bursts wait in a response queue.
  task automatic model_step();
    bit aw_hs, w_hs, b_hs, fin, viol;
    b_t nb;
    aw_t na;
    if (!aresetn) begin
      m_awq.delete();
      m_bq.delete();
      m_beats = 0;
      m_cnt = 0;
      m_err = 1'b0;
      m_started = 1'b0;
      m_wlast_err = 1'b0;
    end else begin
      aw_hs = awvalid && e_awready();
      w_hs  = wvalid && (m_awq.size() > 0);
      b_hs  = bready && (m_bq.size() > 0);
      viol  = 1'b0;
      if (b_hs) void'(m_bq.pop_front());
      if (w_hs) begin
        fin   = (m_beats == m_awq[0].len);
        viol  = CHK && (wlast != fin);
        m_err = m_err | viol;
        if (fin) begin
          nb.id   = m_awq[0].id;
          nb.resp = m_err ? 2'b10 : 2'b00;
          m_bq.push_back(nb);
          void'(m_awq.pop_front());
          m_beats = 0;
          m_err   = 1'b0;
        end else begin
          m_beats++;
        end
      end
      if (aw_hs) begin
        na.id  = awid;
        na.len = int'(awlen);
        m_awq.push_back(na);
      end
      m_cnt = m_cnt + int'(aw_hs) - int'(b_hs);
      m_wlast_err = viol;
      m_started = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge aclk or negedge aresetn);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model, away from the rising edge.
  initial forever begin
    @(negedge aclk);
    chk("awready", 32'(awready), 32'(e_awready()));
    chk("wready", 32'(wready), 32'(m_awq.size() > 0));
    chk("bvalid", 32'(bvalid), 32'(m_bq.size() > 0));
    chk("outstanding_count", 32'(outstanding_count), 32'(m_cnt));
    chk("wlast_err", 32'(wlast_err), 32'(m_wlast_err));
    if (m_bq.size() > 0) begin
      chk("bid", 32'(bid), 32'(m_bq[0].id));
      chk("bresp", 32'(bresp), 32'(m_bq[0].resp));
    end else if (!m_started) begin
      chk("bid_reset", 32'(bid), 32'd0);
      chk("bresp_reset", 32'(bresp), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
  endtask

  task automatic send_aw(input logic [IDW-1:0] id, input logic [7:0] len);
    awvalid = 1'b1; awid = id; awlen = len;
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic drain_all(input int budget);
    int g;
    g = 0;
    awvalid = 1'b0; wvalid = 1'b1; bready = 1'b1;
    while ((m_cnt != 0) && (g < budget)) begin
      wlast = (m_awq.size() > 0) ? (m_beats == m_awq[0].len) : 1'b0;
      @(negedge aclk);
      g++;
    end
    idle_inputs();
    @(negedge aclk);
    chk("drain_count", 32'(outstanding_count), 32'd0);
  endtask

  initial begin
    int exp_bad;
    bit good;
    exp_bad = 0;

    // Reset values
    repeat (3) @(negedge aclk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_count", 32'(outstanding_count), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("awready_after_reset", 32'(awready), 32'd1);

    // Single beat
    send_aw(4'd3, 8'd0);
    chk("single_count1", 32'(outstanding_count), 32'd1);
    chk("single_wready", 32'(wready), 32'd1);
    wvalid = 1'b1; wlast = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    chk("single_bvalid", 32'(bvalid), 32'd1);
    chk("single_bid", 32'(bid), 32'd3);
    chk("single_bresp", 32'(bresp), 32'd0);
    chk("single_count_hold", 32'(outstanding_count), 32'd1);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("single_count0", 32'(outstanding_count), 32'd0);
    chk("single_bvalid_low", 32'(bvalid), 32'd0);

    // Four-beat burst
    send_aw(4'd5, 8'd3);
    wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wlast = (i == 3);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("burst_wready_low", 32'(wready), 32'd0);
    chk("burst_bvalid", 32'(bvalid), 32'd1);
    chk("burst_bid", 32'(bid), 32'd5);
    chk("burst_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;

    // Outstanding limit
    for (int i = 0; i < 16; i++) send_aw(IDW'(i), 8'd0);
    chk("full_count", 32'(outstanding_count), 32'd16);
    chk("full_awready", 32'(awready), 32'd0);
    wvalid = 1'b1; wlast = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    chk("full_bid", 32'(bid), 32'd0);
    chk("full_awready_still0", 32'(awready), 32'd0);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("full_awready_back", 32'(awready), 32'd1);
    chk("full_count15", 32'(outstanding_count), 32'd15);
    drain_all(200);

    // In-order responses under backpressure
    send_aw(4'd1, 8'd0);
    send_aw(4'd2, 8'd0);
    send_aw(4'd3, 8'd0);
    wvalid = 1'b1; wlast = 1'b1;
    repeat (3) @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    chk("order_count", 32'(outstanding_count), 32'd3);
    chk("order_bid1", 32'(bid), 32'd1);
    bready = 1'b1;
    @(negedge aclk);
    chk("order_bid2", 32'(bid), 32'd2);
    @(negedge aclk);
    chk("order_bid3", 32'(bid), 32'd3);
    @(negedge aclk);
    chk("order_empty", 32'(bvalid), 32'd0);
    bready = 1'b0;

    // WLAST on beat 2 of a four-beat burst
    send_aw(4'd7, 8'd3);
    wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wlast = (i == 1);
      @(negedge aclk);
      exp_bad = (CHK && (i == 1 || i == 3)) ? 1 : 0;
      chk("wlast_err_beat", 32'(wlast_err), 32'(exp_bad));
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("wlast_bid", 32'(bid), 32'd7);
    chk("wlast_bresp", 32'(bresp), CHK ? 32'd2 : 32'd0);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;

    // Asynchronous reset in the middle of a burst
    send_aw(4'd9, 8'd3);
    wvalid = 1'b1; wlast = 1'b0;
    repeat (2) @(negedge aclk);
    wvalid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_awready", 32'(awready), 32'd0);
    chk("mid_rst_wready", 32'(wready), 32'd0);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_bid", 32'(bid), 32'd0);
    chk("mid_rst_bresp", 32'(bresp), 32'd0);
    chk("mid_rst_count", 32'(outstanding_count), 32'd0);
    chk("mid_rst_wlast_err", 32'(wlast_err), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    send_aw(4'd4, 8'd0);
    chk("post_rst_count1", 32'(outstanding_count), 32'd1);
    wvalid = 1'b1; wlast = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    chk("post_rst_bid", 32'(bid), 32'd4);
    chk("post_rst_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("post_rst_count0", 32'(outstanding_count), 32'd0);

    // Random traffic with varying backpressure
    for (int c = 0; c < 3000; c++) begin
      awvalid = ($urandom_range(0, 99) < 40);
      awid    = IDW'($urandom);
      awlen   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 3));
      wvalid  = ($urandom_range(0, 99) < 60);
      if (m_awq.size() > 0) begin
        good  = (m_beats == m_awq[0].len);
        wlast = ($urandom_range(0, 99) < 90) ? good : !good;
      end else begin
        wlast = 1'($urandom);
      end
      bready = ($urandom_range(0, 99) < (((c / 500) % 2 == 0) ? 25 : 80));
      @(negedge aclk);
    end
    drain_all(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
